// File: rtl/rvfi_imem_pkg.sv
// Shared types and constants for the RVFI instruction-memory halfword scheduler.
package rvfi_imem_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NRET_DEF = 1;
    localparam int ITEM_MAX = 2 * NRET_DEF;

    typedef struct packed {
        logic [XLEN_DEF-1:0] addr;
        logic [15:0]         data;
    } imem_item_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } sched_state_e;

    // Each retired instruction yields at most two halfword items.
    function automatic int item_max(input int nret);
        return 2 * nret;
    endfunction

endpackage

// File: rtl/rvfi_imem_fifo.sv
// Multi-push (up to MAXPUSH per cycle), single-pop FIFO reporting occupancy and free slots.
module rvfi_imem_fifo #(
    parameter int W       = 48,
    parameter int DEPTH   = 8,
    parameter int MAXPUSH = 2,
    parameter int OCC_W   = $clog2(DEPTH + 1),
    parameter int CNT_W   = $clog2(MAXPUSH + 1)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [CNT_W-1:0]     push_cnt,
    input  logic [MAXPUSH*W-1:0] push_data,
    input  logic                 pop,
    output logic [W-1:0]         head,
    output logic                 empty,
    output logic [OCC_W-1:0]     occupancy,
    output logic [OCC_W-1:0]     free
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             pop_s;

    assign pop_s     = pop && (occ_r != '0);
    assign head      = mem_r[rd_ptr_r];
    assign empty     = (occ_r == '0);
    assign occupancy = occ_r;
    assign free      = OCC_W'(DEPTH) - occ_r;

    // Storage: slot i of the push bundle lands at wr_ptr + i (pointers wrap since DEPTH is 2^n).
    always_ff @(posedge clock) begin
        for (int i = 0; i < MAXPUSH; i++) begin
            if (CNT_W'(i) < push_cnt) begin
                mem_r[wr_ptr_r + PTR_W'(i)] <= push_data[i*W +: W];
            end
        end
    end

    // Pointer and fill-level bookkeeping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
            occ_r    <= occ_r + OCC_W'(push_cnt) - OCC_W'(pop_s);
        end
    end

endmodule

// File: rtl/rvfi_imem_sched.sv
// Serialises RVFI instruction halfwords from all retire channels onto one check port.
// Optional statistics outputs are enabled by defining RVFI_IMEM_SCHED_STATS_EN.
module rvfi_imem_sched #(
    parameter int NRET  = 1,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic [NRET-1:0]              rvfi_valid,
    input  logic [NRET*XLEN-1:0]         rvfi_pc_rdata,
    input  logic [NRET*ILEN-1:0]         rvfi_insn,
    output logic                         chk_valid,
    input  logic                         chk_ready,
    output logic [XLEN-1:0]              chk_addr,
    output logic [15:0]                  chk_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         overflow,
    output logic                         idle
`ifdef RVFI_IMEM_SCHED_STATS_EN
    ,
    output logic [31:0]                  stat_items,
    output logic [$clog2(DEPTH+1)-1:0]   stat_peak
`endif
);

    import rvfi_imem_pkg::*;

    localparam int IMAX   = item_max(NRET);
    localparam int W      = XLEN + 16;
    localparam int CNT_W  = $clog2(IMAX + 1);
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int FREE_W = OCC_W + 1;

    sched_state_e      state_r;
    sched_state_e      state_nxt_s;
    logic              overflow_r;
    logic              overflow_nxt_s;
    logic [IMAX*W-1:0] items_s;
    logic [CNT_W-1:0]  n_items_s;
    logic [CNT_W-1:0]  push_cnt_s;
    logic [FREE_W-1:0] free_s;
    logic              pop_s;
    logic              empty_s;
    logic [W-1:0]      head_s;
    logic [OCC_W-1:0]  occ_s;
    logic [OCC_W-1:0]  fifo_free_s;

    // Expand valid retirements into a compacted, ordered list of halfword items.
    always_comb begin
        items_s   = '0;
        n_items_s = '0;
        for (int c = 0; c < NRET; c++) begin
            if (enable && rvfi_valid[c]) begin
                items_s[int'(n_items_s)*W +: W] = {rvfi_pc_rdata[c*XLEN +: XLEN], rvfi_insn[c*ILEN +: 16]};
                n_items_s = n_items_s + CNT_W'(1);
                if (rvfi_insn[c*ILEN +: 2] == 2'b11) begin
                    items_s[int'(n_items_s)*W +: W] = {rvfi_pc_rdata[c*XLEN +: XLEN] + XLEN'(2),
                                                       rvfi_insn[c*ILEN+16 +: 16]};
                    n_items_s = n_items_s + CNT_W'(1);
                end else begin
                    n_items_s = n_items_s;
                end
            end else begin
                n_items_s = n_items_s;
            end
        end
    end

    assign pop_s  = !empty_s && chk_ready;
    assign free_s = {1'b0, fifo_free_s} + FREE_W'(pop_s);

    // All-or-nothing capacity decision; any loss moves to FAULT until reset.
    always_comb begin
        state_nxt_s    = state_r;
        overflow_nxt_s = overflow_r;
        push_cnt_s     = '0;
        case (state_r)
            RUN: begin
                if (int'(n_items_s) <= int'(free_s)) begin
                    push_cnt_s = n_items_s;
                end else begin
                    state_nxt_s    = FAULT;
                    overflow_nxt_s = 1'b1;
                end
            end
            FAULT: begin
                state_nxt_s = FAULT;
            end
            default: begin
                state_nxt_s = FAULT;
            end
        endcase
    end

    // Scheduler state and sticky overflow flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= RUN;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    rvfi_imem_fifo #(
        .W       (W),
        .DEPTH   (DEPTH),
        .MAXPUSH (IMAX),
        .OCC_W   (OCC_W),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push_cnt  (push_cnt_s),
        .push_data (items_s),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (empty_s),
        .occupancy (occ_s),
        .free      (fifo_free_s)
    );

    // Head fields are forced to zero when empty so reset values are deterministic.
    assign chk_valid = !empty_s;
    assign chk_addr  = empty_s ? '0 : head_s[W-1:16];
    assign chk_data  = empty_s ? 16'h0000 : head_s[15:0];
    assign occupancy = occ_s;
    assign overflow  = overflow_r;
    assign idle      = empty_s && (state_r == RUN);

`ifdef RVFI_IMEM_SCHED_STATS_EN
    logic [31:0]      stat_items_r;
    logic [OCC_W-1:0] stat_peak_r;
    logic [OCC_W-1:0] occ_nxt_s;

    assign occ_nxt_s  = occ_s + OCC_W'(push_cnt_s) - OCC_W'(pop_s);
    assign stat_items = stat_items_r;
    assign stat_peak  = stat_peak_r;

    // Saturating pop counter and high-water mark of the fill level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stat_items_r <= 32'h0000_0000;
            stat_peak_r  <= '0;
        end else begin
            if (pop_s && (stat_items_r != 32'hFFFF_FFFF)) begin
                stat_items_r <= stat_items_r + 32'd1;
            end
            if (occ_nxt_s > stat_peak_r) begin
                stat_peak_r <= occ_nxt_s;
            end
        end
    end
`endif

endmodule
